// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, midpoint sampling, valid/ready hold.
// Define UART_RX_SYNC_EN to add a 2-flop synchroniser on rx_in.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 26,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;

  // START begins one cycle after the falling edge is seen, hence H-1
  localparam logic [CW-1:0] H_M1 = CW'(H - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_in};
  end

  assign rx = sync[1];
`else
  assign rx = rx_in;
`endif

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bitn;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 commit;
  logic [DATA_BITS-1:0] c_data;
  logic                 c_perr;
  logic                 c_ferr;
  logic                 tick;
  logic                 perr;
  logic                 stop_bad;

  assign tick     = (cnt == LAST);
  assign stop_bad = ferr_acc | ~rx;
  assign rx_busy  = (state != IDLE);

  always_comb begin
    perr = 1'b0;
    if (PARITY_MODE == 1)      perr = ~(^shreg ^ par_bit);
    else if (PARITY_MODE == 2) perr = ^shreg ^ par_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      commit   <= 1'b0;
      c_data   <= '0;
      c_perr   <= 1'b0;
      c_ferr   <= 1'b0;
    end else begin
      commit <= 1'b0;
      cnt    <= cnt + CW'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) state <= START;
        end
        START: begin
          if (cnt == H_M1) begin
            cnt   <= '0;
            state <= rx ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            shreg <= {rx, shreg[DATA_BITS-1:1]};
            bitn  <= bitn + 4'd1;
            if (bitn == DB_LAST) begin
              bitn     <= '0;
              ferr_acc <= 1'b0;
              state    <= (PARITY_MODE != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            cnt     <= '0;
            par_bit <= rx;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            cnt      <= '0;
            bitn     <= bitn + 4'd1;
            ferr_acc <= stop_bad;
            if (bitn == SB_LAST) begin
              bitn   <= '0;
              commit <= 1'b1;
              c_data <= shreg;
              c_perr <= perr;
              c_ferr <= stop_bad;
              state  <= stop_bad ? WAIT_HIGH : IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_valid   <= 1'b1;
          rx_data    <= c_data;
          parity_err <= c_perr;
          frame_err  <= c_ferr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations checked every cycle against a
// timestamp-based line model, plus directed latency/error/overrun/reset checks.
`timescale 1ns/1ps
module tb_uart_rx_param;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] rdy = 3'b111;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [4:0] d2;
  logic [2:0] v, pe, fe, ov, busy;
  logic [8:0] dq [3];

  assign dq[0] = {1'b0, d0};
  assign dq[1] = {2'b0, d1};
  assign dq[2] = {4'b0, d2};

  always #5 clk = ~clk;

  uart_rx_param u0 (
    .clk(clk), .rst_n(rst_n), .rx_in(line[0]), .rx_data(d0),
    .rx_valid(v[0]), .rx_ready(rdy[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun(ov[0]), .rx_busy(busy[0])
  );

  uart_rx_param #(
    .CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .rx_in(line[1]), .rx_data(d1),
    .rx_valid(v[1]), .rx_ready(rdy[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun(ov[1]), .rx_busy(busy[1])
  );

  uart_rx_param #(
    .CLKS_PER_BIT(5), .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .rx_in(line[2]), .rx_data(d2),
    .rx_valid(v[2]), .rx_ready(rdy[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .overrun(ov[2]), .rx_busy(busy[2])
  );

  function automatic int cpb(int i);
    return (i == 0) ? 26 : (i == 1) ? 8 : 5;
  endfunction
  function automatic int db(int i);
    return (i == 0) ? 8 : (i == 1) ? 7 : 5;
  endfunction
  function automatic int pm(int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 1;
  endfunction
  function automatic int sb(int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int hh(int i);
    return (cpb(i) - 1) / 2;
  endfunction
  function automatic int pp(int i);
    return (pm(i) != 0) ? 1 : 0;
  endfunction
  function automatic bit good_par(int i, int w);
    int n;
    n = $countones(w & ((1 << db(i)) - 1));
    return (pm(i) == 1) ? (n % 2 == 0) : ((n % 2) == 1);
  endfunction

  int ncmp = 0;
  int nbad = 0;
  int cyc = 0;

  // model state: mode 0 idle, 1 in frame, 2 waiting for high line
  int mode [3];
  int t0m  [3];
  bit hist [3][1024];
  bit s1 [3], s2 [3];
  bit mv [3], mpe [3], mfe [3], mov [3];
  bit pend [3], ppe [3], pfe [3];
  int md [3], pd [3];

  task automatic step(input int i);
    bit e, perr, ferr;
    int base, c, w, par;
    if (!rst_n) begin
      mode[i] = 0; mv[i] = 0; md[i] = 0; mpe[i] = 0; mfe[i] = 0;
      mov[i] = 0; pend[i] = 0; s1[i] = 1; s2[i] = 1;
      return;
    end
    if (LAT == 2) begin
      e = s2[i]; s2[i] = s1[i]; s1[i] = line[i];
    end else begin
      e = line[i];
    end
    hist[i][cyc % 1024] = e;
    mov[i] = 0;
    if (pend[i]) begin
      if (!mv[i] || rdy[i]) begin
        mv[i] = 1; md[i] = pd[i]; mpe[i] = ppe[i]; mfe[i] = pfe[i];
      end else begin
        mov[i] = 1;
      end
    end else if (mv[i] && rdy[i]) begin
      mv[i] = 0; mpe[i] = 0; mfe[i] = 0;
    end
    pend[i] = 0;
    c = cpb(i);
    base = t0m[i] + hh(i);
    case (mode[i])
      0: if (!e) begin mode[i] = 1; t0m[i] = cyc; end
      1: begin
        if (cyc == base) begin
          if (e) mode[i] = 0;
        end else if (cyc == base + (1 + db(i) + pp(i) + sb(i) - 1) * c) begin
          w = 0;
          for (int k = 0; k < db(i); k++)
            if (hist[i][(base + (k + 1) * c) % 1024]) w |= (1 << k);
          par = pp(i) ? int'(hist[i][(base + (db(i) + 1) * c) % 1024]) : 0;
          perr = 0;
          if (pm(i) == 1) perr = (($countones(w) + par) % 2) == 0;
          if (pm(i) == 2) perr = (($countones(w) + par) % 2) == 1;
          ferr = 0;
          for (int s = 0; s < sb(i); s++)
            if (!hist[i][(base + (db(i) + pp(i) + 1 + s) * c) % 1024]) ferr = 1;
          pend[i] = 1; pd[i] = w; ppe[i] = perr; pfe[i] = ferr;
          mode[i] = ferr ? 2 : 0;
        end
      end
      default: if (e) mode[i] = 0;
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) step(i);
  end

  int rise_n [3], rise_c [3], cap_d [3], vlen [3];
  int ov_n [3], ov_c [3], bfall [3], t0s [3];
  bit cap_pe [3], cap_fe [3], pv [3], pbusy [3];

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        ncmp++;
        if (v[i] !== mv[i] || dq[i] !== 9'(md[i]) || pe[i] !== mpe[i] ||
            fe[i] !== mfe[i] || ov[i] !== mov[i] ||
            busy[i] !== (mode[i] != 0)) begin
          nbad++;
          if (nbad <= 20)
            $display("FAIL cycle_u%0d cyc %0d: v/d/pe/fe/ov/busy got %b/%h/%b/%b/%b/%b expected %b/%h/%b/%b/%b/%b",
                     i, cyc, v[i], dq[i], pe[i], fe[i], ov[i], busy[i],
                     mv[i], 9'(md[i]), mpe[i], mfe[i], mov[i], mode[i] != 0);
        end
        if (v[i] && !pv[i]) begin
          rise_n[i]++; rise_c[i] = cyc; cap_d[i] = int'(dq[i]);
          cap_pe[i] = pe[i]; cap_fe[i] = fe[i]; vlen[i] = 0;
        end
        if (v[i]) vlen[i]++;
        if (ov[i]) begin ov_n[i]++; ov_c[i] = cyc; end
        if (!busy[i] && pbusy[i]) bfall[i] = cyc;
        pv[i] = v[i];
        pbusy[i] = busy[i];
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int i, input int w, input bit par,
                      input int stops, input int cut);
    bit bits [16];
    int n;
    n = 0;
    bits[n++] = 1'b0;
    for (int k = 0; k < db(i); k++) bits[n++] = 1'((w >> k) & 1);
    if (pp(i) != 0) bits[n++] = par;
    for (int s = 0; s < sb(i); s++) bits[n++] = 1'((stops >> s) & 1);
    @(negedge clk);
    t0s[i] = cyc + 1;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < cpb(i); c++) begin
        if (cut != 0 && b * cpb(i) + c >= cut) begin
          line[i] = 1'b1;
          return;
        end
        line[i] = bits[b];
        @(negedge clk);
      end
    end
    line[i] = 1'b1;
  endtask

  task automatic rand_traffic(input int i, input int n);
    int w, k, m;
    for (int j = 0; j < n; j++) begin
      w = int'($urandom) & ((1 << db(i)) - 1);
      k = int'($urandom_range(0, 9));
      if (k == 0) begin
        line[i] = 1'b0;
        idle(int'($urandom_range(1, 2 * hh(i))));
        line[i] = 1'b1;
      end else begin
        m = (k == 2) ? int'($urandom_range(0, 3)) : 3;
        send(i, w, (k == 1) ? !good_par(i, w) : good_par(i, w), m, 0);
        if (k == 3) begin
          line[i] = 1'b0;
          idle(int'($urandom_range(1, 3 * cpb(i))));
          line[i] = 1'b1;
        end
      end
      idle(int'($urandom_range(0, 30)));
    end
  endtask

  bit rr_en = 0;

  always @(negedge clk)
    if (rr_en) rdy = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, o0, t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(v), 0);
    check("rst_data", int'(dq[0]), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(ov), 0);
    rst_n = 1'b1;
    idle(5);

    r0 = rise_n[0];
    send(0, 'hA5, 1'b0, 1, 0);
    idle(20);
    check("a5_count", rise_n[0] - r0, 1);
    check("a5_latency", rise_c[0] - t0s[0], 247 + LAT);
    check("a5_len", vlen[0], 1);
    check("a5_data", cap_d[0], 'hA5);
    check("a5_perr", int'(cap_pe[0]), 0);
    check("a5_ferr", int'(cap_fe[0]), 0);

    r0 = rise_n[0];
    @(negedge clk);
    line[0] = 1'b0;
    t = cyc + 1;
    idle(10);
    line[0] = 1'b1;
    idle(60);
    check("glitch_novalid", rise_n[0] - r0, 0);
    check("glitch_busyfall", bfall[0] - t, 12 + LAT);

    r0 = rise_n[1];
    send(1, 'h35, 1'b1, 3, 0);
    idle(20);
    check("par_count", rise_n[1] - r0, 1);
    check("par_latency", rise_c[1] - t0s[1], 84 + LAT);
    check("par_bad_data", cap_d[1], 'h35);
    check("par_bad_perr", int'(cap_pe[1]), 1);
    send(1, 'h35, 1'b0, 3, 0);
    idle(20);
    check("par_ok_perr", int'(cap_pe[1]), 0);
    check("par_ok_data", cap_d[1], 'h35);

    r0 = rise_n[0];
    send(0, 'h00, 1'b0, 0, 0);
    line[0] = 1'b0;
    idle(100);
    line[0] = 1'b1;
    idle(30);
    check("brk_count", rise_n[0] - r0, 1);
    check("brk_data", cap_d[0], 0);
    check("brk_ferr", int'(cap_fe[0]), 1);
    check("brk_idle", int'(busy[0]), 0);

    rdy[0] = 1'b0;
    r0 = rise_n[0];
    o0 = ov_n[0];
    send(0, 'h11, 1'b0, 1, 0);
    send(0, 'h22, 1'b0, 1, 0);
    idle(20);
    check("ovr_rises", rise_n[0] - r0, 1);
    check("ovr_pulses", ov_n[0] - o0, 1);
    check("ovr_when", ov_c[0] - t0s[0], 247 + LAT);
    check("ovr_hold", int'(dq[0]), 'h11);
    check("ovr_valid", int'(v[0]), 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    check("ovr_drain", int'(v[0]), 0);
    check("ovr_keep", int'(dq[0]), 'h11);

    r0 = rise_n[0];
    send(0, 'h5A, 1'b0, 1, 4 * 26 + 13);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_valid", int'(v[0]), 0);
    check("mid_rst_data", int'(dq[0]), 0);
    check("mid_rst_busy", int'(busy[0]), 0);
    idle(300);
    check("mid_rst_novalid", rise_n[0] - r0, 0);
    send(0, 'hC3, 1'b0, 1, 0);
    idle(20);
    check("c3_count", rise_n[0] - r0, 1);
    check("c3_data", cap_d[0], 'hC3);

    rr_en = 1'b1;
    fork
      rand_traffic(0, 25);
      rand_traffic(1, 40);
      rand_traffic(2, 60);
    join
    rr_en = 1'b0;
    rdy = 3'b111;
    idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 receiver. Configurable clocks-per-bit, data width, parity and stop-bit count. Samples each bit at its midpoint and rejects start-bit glitches. Delivers each frame through a valid/ready holding register with parity, framing and overrun status. Sits between the serial pad `rx_in` and the byte-consuming logic, and pairs with the existing transmitter.

Parameters:
- CLKS_PER_BIT, 26, clk cycles per serial bit; legal range >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- rx_in  in  1  serial line; idle high.
- rx_data  out  DATA_BITS  received word, stable while rx_valid = 1.
- rx_valid  out  1  word available in the holding register.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- parity_err  out  1  parity mismatch for the held word; qualified by rx_valid.
- frame_err  out  1  a stop bit was sampled 0 for the held word; qualified by rx_valid.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n = 0 at a posedge):
  - state = IDLE; bit and cycle counters = 0.
  - All outputs = 0, including rx_data.
  - Reset mid-frame aborts the frame; no rx_valid results from it.
- Definitions:
  - H = (CLKS_PER_BIT-1)/2, integer division.
  - P = 1 if PARITY_MODE != 0, else 0.
  - Cycle counter width = $clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rx_in == 0 at cycle t0 -> START, counter cleared.
  - START: at counter == H, sample rx_in.
    - Sample 0 -> DATA, counter cleared.
    - Sample 1 -> IDLE (glitch rejected; no flags, no output).
  - DATA: sample every CLKS_PER_BIT cycles; bit k at t0+H+(k+1)*CLKS_PER_BIT, shifted in LSB first. After DATA_BITS samples -> PARITY if P = 1, else STOP.
  - PARITY: one sample.
    - Odd mode: error if XOR(data, parity bit) == 0.
    - Even mode: error if XOR(data, parity bit) == 1.
  - STOP: STOP_BITS samples; any 0 sets the frame error. The frame commits on the last stop sample, at t0+H+(DATA_BITS+P+1+STOP_BITS-1)*CLKS_PER_BIT.
    - No frame error -> IDLE in the same step, so a back-to-back start edge is caught from the next cycle.
    - Frame error -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_in == 1, then -> IDLE. This handles a break (line held low).
- Commit, registered; rx_valid goes high the cycle after the commit sample:
  - rx_valid = 0, or rx_valid && rx_ready this cycle: load rx_data, parity_err, frame_err; rx_valid = 1.
  - rx_valid = 1 && rx_ready = 0: new frame discarded; held word unchanged; overrun = 1 for exactly one cycle.
- Handshake:
  - rx_valid && rx_ready without a commit -> rx_valid = 0 next cycle.
  - parity_err and frame_err clear together with rx_valid.
  - rx_data holds its last value after consumption.
- Example latency, CLKS_PER_BIT = 26, 8N1: commit sample at t0+246, rx_valid at t0+247.
- rx_in transitions during non-sample cycles are ignored. No majority voting.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx_in passes through a 2-flop synchroniser before all logic. The synchroniser flops reset to 1 with rst_n. Every timing figure above moves 2 cycles later (8N1 at 26: rx_valid at t0+249, t0 = line fall).
- Undefined: rx_in is used directly; rx_in must already be synchronous to clk.

Test Plan:
- Defaults, rx_ready = 1, frame 0xA5 (8N1), line falls at t0 -> rx_valid at t0+247 for exactly 1 cycle; rx_data = 0xA5; parity_err = 0; frame_err = 0.
- Low pulse of 10 cycles on an idle line (CLKS_PER_BIT = 26) -> returns to IDLE; rx_valid never asserts; rx_busy drops after 13 cycles.
- PARITY_MODE = 2, DATA_BITS = 7, send 0x35 with a wrong parity bit of 1 -> rx_data = 0x35, parity_err = 1; correct parity bit 0 -> parity_err = 0.
- Frame 0x00 with stop bit 0, then line held low 100 cycles, then high -> frame_err = 1 with rx_data = 0x00; no second frame until the line has been high and falls again.
- rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11; overrun pulses once at the 0x22 commit; then rx_ready = 1 -> rx_valid drops next cycle.
- Reset asserted for 1 cycle at mid data bit 3 of 0x5A -> all outputs 0; no rx_valid; next clean frame 0xC3 is received correctly.
